// File: rtl/rv32v_mem_deserializer_pkg.sv
// Shared types for the vector load-return path: element widths, lane count, deserializer states.
package rv32v_types_pkg;

  localparam int NUM_LANES = 2;

  typedef enum logic [1:0] {
    SEW8  = 2'd0,
    SEW16 = 2'd1,
    SEW32 = 2'd2
  } vsew_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WB      = 2'd2
  } deser_state_t;

  // A returned word cannot hold an element whose offset straddles its natural alignment.
  function automatic logic sew_misaligned(input vsew_t eew, input logic [1:0] boff);
    logic bad;
    bad = 1'b0;
    case (eew)
      SEW16:   bad = boff[0];
      SEW32:   bad = (boff != 2'd0);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/rv32v_mem_deserializer_if.sv
// Uop issue, LSC response and writeback signals of the vector load deserializer.
interface rv32v_mem_deserializer_if #(
  parameter int NUM_LANES = 2,
  parameter int WORD_W    = 32
);
  import rv32v_types_pkg::*;

  localparam int LANE_W = $clog2(NUM_LANES);

  logic                          start;
  logic                          vmemdren;
  logic [4:0]                    vuop_num;
  logic                          vuop_last;
  vsew_t                         veew;
  logic [NUM_LANES-1:0]          vlane_mask;
  logic                          busy;
  logic                          lsc_rvalid;
  logic [LANE_W-1:0]             lsc_rlane;
  logic [WORD_W-1:0]             lsc_rdata;
  logic [1:0]                    lsc_boff;
  logic                          flush;
  logic                          wb_valid;
  logic                          wb_ready;
  logic [NUM_LANES*WORD_W-1:0]   wb_data;
  logic [NUM_LANES-1:0]          wb_mask;
  logic [4:0]                    wb_uop_num;
  logic                          wb_last;
  logic                          err;

  modport master (
    output start, vmemdren, vuop_num, vuop_last, veew, vlane_mask,
    output lsc_rvalid, lsc_rlane, lsc_rdata, lsc_boff, flush, wb_ready,
    input  busy, wb_valid, wb_data, wb_mask, wb_uop_num, wb_last, err
  );

  modport slave (
    input  start, vmemdren, vuop_num, vuop_last, veew, vlane_mask,
    input  lsc_rvalid, lsc_rlane, lsc_rdata, lsc_boff, flush, wb_ready,
    output busy, wb_valid, wb_data, wb_mask, wb_uop_num, wb_last, err
  );

endinterface

// File: rtl/rv32v_load_extract.sv
// Combinational element extraction from an aligned load word with zero extension to 32 bits.
module rv32v_load_extract (
  input  logic [31:0]            rdata,
  input  logic [1:0]             boff,
  input  rv32v_types_pkg::vsew_t veew,
  output logic [31:0]            ext
);
  import rv32v_types_pkg::*;

  always_comb begin
    ext = rdata;
    case (veew)
      SEW8:    ext = {24'd0, rdata[{boff, 3'b000} +: 8]};
      SEW16:   ext = {16'd0, rdata[{boff[1], 4'b0000} +: 16]};
      default: ext = rdata;
    endcase
  end

endmodule

// File: rtl/rv32v_mem_deserializer.sv
// Collects per-lane load responses for one vector uop and emits a packed writeback beat.
// Optional protocol checking is enabled with the RV32V_DESER_ERRCHK_EN macro.
module rv32v_mem_deserializer #(
  parameter int NUM_LANES = rv32v_types_pkg::NUM_LANES,
  parameter int WORD_W    = 32
) (
  input logic                    CLK,
  input logic                    RST,
  rv32v_mem_deserializer_if.slave bus
);
  import rv32v_types_pkg::*;

  deser_state_t                state_q;
  deser_state_t                state_d;
  logic [NUM_LANES-1:0]        done_q;
  logic [NUM_LANES-1:0]        done_d;
  logic [NUM_LANES-1:0]        mask_q;
  logic [NUM_LANES*WORD_W-1:0] data_q;
  logic [4:0]                  uop_num_q;
  logic                        last_q;
  vsew_t                       eew_q;
  logic [31:0]                 ext_word;
  logic [NUM_LANES-1:0]        resp_onehot;
  logic                        resp_take;
  logic                        accept_start;

  rv32v_load_extract u_extract (
    .rdata (bus.lsc_rdata),
    .boff  (bus.lsc_boff),
    .veew  (eew_q),
    .ext   (ext_word)
  );

  always_comb begin
    resp_onehot = '0;
    if (bus.lsc_rvalid) resp_onehot[bus.lsc_rlane] = 1'b1;
  end

  // Only the first response for an active lane of the current uop is kept.
  assign resp_take = (state_q == COLLECT) && bus.lsc_rvalid &&
                     !done_q[bus.lsc_rlane] && !bus.flush;
  assign done_d    = done_q | (resp_onehot & {NUM_LANES{resp_take}});

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    accept_start = 1'b0;
    if (bus.flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start && bus.vmemdren) begin
            state_d      = COLLECT;
            accept_start = 1'b1;
          end
        end
        COLLECT: begin
          if (&done_d) state_d = WB;
        end
        WB: begin
          if (bus.wb_ready) begin
            if (bus.start && bus.vmemdren) begin
              state_d      = COLLECT;
              accept_start = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Uop context and lane data; masked lanes start pre-completed with zero data.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      done_q    <= '0;
      mask_q    <= '0;
      data_q    <= '0;
      uop_num_q <= '0;
      last_q    <= 1'b0;
      eew_q     <= SEW8;
    end else if (bus.flush) begin
      done_q <= '0;
    end else if (accept_start) begin
      done_q    <= ~bus.vlane_mask;
      mask_q    <= bus.vlane_mask;
      data_q    <= '0;
      uop_num_q <= bus.vuop_num;
      last_q    <= bus.vuop_last;
      eew_q     <= bus.veew;
    end else if (resp_take) begin
      done_q                                  <= done_d;
      data_q[bus.lsc_rlane*WORD_W +: WORD_W] <= ext_word;
    end
  end

  assign bus.busy       = (state_q != IDLE);
  assign bus.wb_valid   = (state_q == WB);
  assign bus.wb_data    = data_q;
  assign bus.wb_mask    = mask_q;
  assign bus.wb_uop_num = uop_num_q;
  assign bus.wb_last    = last_q;

`ifdef RV32V_DESER_ERRCHK_EN
  logic err_q;
  logic err_hit;

  always_comb begin
    err_hit = 1'b0;
    if (bus.lsc_rvalid) begin
      if ((state_q != COLLECT) || done_q[bus.lsc_rlane]) err_hit = 1'b1;
      if (sew_misaligned(eew_q, bus.lsc_boff))           err_hit = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)          err_q <= 1'b0;
    else if (err_hit) err_q <= 1'b1;
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_rv32v_mem_deserializer.sv
// Scoreboard bench for rv32v_mem_deserializer with two lanes.
module tb_rv32v_mem_deserializer;
  import rv32v_types_pkg::*;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  mask;
    logic [4:0]  uop;
    logic        last;
  } beat_t;

`ifdef RV32V_DESER_ERRCHK_EN
  localparam logic ERRCHK = 1'b1;
`else
  localparam logic ERRCHK = 1'b0;
`endif

  logic  CLK;
  logic  RST;
  int    checks;
  int    failures;
  beat_t sb_q[$];
  beat_t mon_exp;

  rv32v_mem_deserializer_if #(.NUM_LANES(2), .WORD_W(32)) bus ();

  rv32v_mem_deserializer #(.NUM_LANES(2), .WORD_W(32)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Every accepted writeback beat must match the oldest expectation.
  always @(negedge CLK) begin
    if (!RST && bus.wb_valid && bus.wb_ready) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_beat got uop=%0d data=%h", bus.wb_uop_num, bus.wb_data);
      end else begin
        mon_exp = sb_q.pop_front();
        if (bus.wb_data !== mon_exp.data) begin
          failures++;
          $display("FAIL sb_data got=%h exp=%h", bus.wb_data, mon_exp.data);
        end
        checks++;
        if (bus.wb_mask !== mon_exp.mask) begin
          failures++;
          $display("FAIL sb_mask got=%b exp=%b", bus.wb_mask, mon_exp.mask);
        end
        checks++;
        if (bus.wb_uop_num !== mon_exp.uop) begin
          failures++;
          $display("FAIL sb_uop got=%0d exp=%0d", bus.wb_uop_num, mon_exp.uop);
        end
        checks++;
        if (bus.wb_last !== mon_exp.last) begin
          failures++;
          $display("FAIL sb_last got=%b exp=%b", bus.wb_last, mon_exp.last);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input logic [4:0] uop, input logic last, input vsew_t eew,
                       input logic [1:0] mask);
    bus.start      = 1'b1;
    bus.vmemdren   = 1'b1;
    bus.vuop_num   = uop;
    bus.vuop_last  = last;
    bus.veew       = eew;
    bus.vlane_mask = mask;
    tick();
    bus.start    = 1'b0;
    bus.vmemdren = 1'b0;
  endtask

  task automatic resp(input logic lane, input logic [31:0] data, input logic [1:0] boff);
    bus.lsc_rvalid = 1'b1;
    bus.lsc_rlane  = lane;
    bus.lsc_rdata  = data;
    bus.lsc_boff   = boff;
    tick();
    bus.lsc_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    @(negedge CLK);
    checks++; if (bus.busy !== 1'b0)       begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.wb_valid !== 1'b0)   begin failures++; $display("FAIL reset_wb_valid got=%b exp=0", bus.wb_valid); end
    checks++; if (bus.wb_data !== 64'd0)   begin failures++; $display("FAIL reset_wb_data got=%h exp=0", bus.wb_data); end
    checks++; if (bus.wb_mask !== 2'b00)   begin failures++; $display("FAIL reset_wb_mask got=%b exp=00", bus.wb_mask); end
    checks++; if (bus.wb_uop_num !== 5'd0) begin failures++; $display("FAIL reset_wb_uop got=%0d exp=0", bus.wb_uop_num); end
    checks++; if (bus.wb_last !== 1'b0)    begin failures++; $display("FAIL reset_wb_last got=%b exp=0", bus.wb_last); end
    checks++; if (bus.err !== 1'b0)        begin failures++; $display("FAIL reset_err got=%b exp=0", bus.err); end
    tick();
    RST = 1'b0;
    tick();
    bus.start    = 1'b1;
    bus.vmemdren = 1'b0;
    tick();
    bus.start = 1'b0;
    @(negedge CLK);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL start_not_load busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_sew32();
    tick();
    bus.wb_ready = 1'b1;
    sb_q.push_back('{data: 64'hDEADBEEF_01234567, mask: 2'b11, uop: 5'd1, last: 1'b0});
    issue(5'd1, 1'b0, SEW32, 2'b11);
    @(negedge CLK);
    checks++; if (bus.busy !== 1'b1)     begin failures++; $display("FAIL sew32_busy got=%b exp=1", bus.busy); end
    checks++; if (bus.wb_valid !== 1'b0) begin failures++; $display("FAIL sew32_early_valid got=%b exp=0", bus.wb_valid); end
    resp(1'b1, 32'hDEADBEEF, 2'd0);
    @(negedge CLK);
    checks++; if (bus.wb_valid !== 1'b0) begin failures++; $display("FAIL sew32_half_valid got=%b exp=0", bus.wb_valid); end
    resp(1'b0, 32'h01234567, 2'd0);
    @(negedge CLK);
    checks++; if (bus.wb_valid !== 1'b1) begin failures++; $display("FAIL sew32_wb_valid got=%b exp=1", bus.wb_valid); end
    tick();
    @(negedge CLK);
    checks++; if (bus.busy !== 1'b0)     begin failures++; $display("FAIL sew32_idle_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_sew8_masked();
    tick();
    bus.wb_ready = 1'b1;
    sb_q.push_back('{data: 64'h00000000_000000BB, mask: 2'b01, uop: 5'd2, last: 1'b1});
    issue(5'd2, 1'b1, SEW8, 2'b01);
    resp(1'b0, 32'hAABBCCDD, 2'd2);
    @(negedge CLK);
    checks++; if (bus.wb_valid !== 1'b1)         begin failures++; $display("FAIL sew8_wb_valid got=%b exp=1", bus.wb_valid); end
    checks++; if (bus.wb_data[31:0] !== 32'hBB)  begin failures++; $display("FAIL sew8_lane0 got=%h exp=000000bb", bus.wb_data[31:0]); end
    tick();
  endtask

  task automatic test_sew16();
    tick();
    bus.wb_ready = 1'b1;
    sb_q.push_back('{data: 64'h00007788_00001122, mask: 2'b11, uop: 5'd10, last: 1'b0});
    issue(5'd10, 1'b0, SEW16, 2'b11);
    resp(1'b0, 32'h11223344, 2'd2);
    resp(1'b1, 32'h55667788, 2'd0);
    @(negedge CLK);
    checks++; if (bus.wb_valid !== 1'b1) begin failures++; $display("FAIL sew16_wb_valid got=%b exp=1", bus.wb_valid); end
    tick();
  endtask

  task automatic test_all_masked();
    tick();
    bus.wb_ready = 1'b1;
    sb_q.push_back('{data: 64'd0, mask: 2'b00, uop: 5'd7, last: 1'b1});
    issue(5'd7, 1'b1, SEW32, 2'b00);
    @(negedge CLK);
    checks++; if (bus.wb_valid !== 1'b0)   begin failures++; $display("FAIL masked_early_valid got=%b exp=0", bus.wb_valid); end
    tick();
    @(negedge CLK);
    checks++; if (bus.wb_valid !== 1'b1)   begin failures++; $display("FAIL masked_wb_valid got=%b exp=1", bus.wb_valid); end
    checks++; if (bus.wb_uop_num !== 5'd7) begin failures++; $display("FAIL masked_uop got=%0d exp=7", bus.wb_uop_num); end
    tick();
    @(negedge CLK);
    checks++; if (bus.busy !== 1'b0)       begin failures++; $display("FAIL masked_idle got=%b exp=0", bus.busy); end
  endtask

  task automatic test_back_to_back();
    tick();
    bus.wb_ready = 1'b0;
    sb_q.push_back('{data: 64'hB1B1B1B1_A0A0A0A0, mask: 2'b11, uop: 5'd3, last: 1'b0});
    issue(5'd3, 1'b0, SEW32, 2'b11);
    resp(1'b0, 32'hA0A0A0A0, 2'd0);
    resp(1'b1, 32'hB1B1B1B1, 2'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      checks++; if (bus.wb_valid !== 1'b1) begin failures++; $display("FAIL stall_valid cyc=%0d got=%b exp=1", i, bus.wb_valid); end
      checks++; if (bus.wb_data !== 64'hB1B1B1B1_A0A0A0A0) begin failures++; $display("FAIL stall_data cyc=%0d got=%h exp=b1b1b1b1a0a0a0a0", i, bus.wb_data); end
      checks++; if (bus.wb_uop_num !== 5'd3) begin failures++; $display("FAIL stall_uop cyc=%0d got=%0d exp=3", i, bus.wb_uop_num); end
      tick();
    end
    bus.wb_ready   = 1'b1;
    bus.start      = 1'b1;
    bus.vmemdren   = 1'b1;
    bus.vuop_num   = 5'd4;
    bus.vuop_last  = 1'b1;
    bus.veew       = SEW32;
    bus.vlane_mask = 2'b10;
    sb_q.push_back('{data: 64'h12345678_00000000, mask: 2'b10, uop: 5'd4, last: 1'b1});
    @(negedge CLK);
    tick();
    bus.start    = 1'b0;
    bus.vmemdren = 1'b0;
    @(negedge CLK);
    checks++; if (bus.busy !== 1'b1)     begin failures++; $display("FAIL b2b_busy got=%b exp=1", bus.busy); end
    checks++; if (bus.wb_valid !== 1'b0) begin failures++; $display("FAIL b2b_valid got=%b exp=0", bus.wb_valid); end
    resp(1'b1, 32'h12345678, 2'd0);
    @(negedge CLK);
    checks++; if (bus.wb_valid !== 1'b1) begin failures++; $display("FAIL b2b_wb_valid got=%b exp=1", bus.wb_valid); end
    tick();
  endtask

  task automatic test_err_dup();
    tick();
    bus.wb_ready = 1'b1;
    sb_q.push_back('{data: 64'h33333333_11111111, mask: 2'b11, uop: 5'd8, last: 1'b0});
    issue(5'd8, 1'b0, SEW32, 2'b11);
    @(negedge CLK);
    checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL err_before_dup got=%b exp=0", bus.err); end
    resp(1'b0, 32'h11111111, 2'd0);
    resp(1'b0, 32'h22222222, 2'd0);
    @(negedge CLK);
    checks++; if (bus.err !== ERRCHK)   begin failures++; $display("FAIL err_dup got=%b exp=%b", bus.err, ERRCHK); end
    checks++; if (bus.busy !== 1'b1)    begin failures++; $display("FAIL dup_busy got=%b exp=1", bus.busy); end
    resp(1'b1, 32'h33333333, 2'd0);
    @(negedge CLK);
    checks++; if (bus.wb_valid !== 1'b1) begin failures++; $display("FAIL dup_wb_valid got=%b exp=1", bus.wb_valid); end
    tick();
  endtask

  task automatic test_flush();
    tick();
    bus.wb_ready = 1'b1;
    issue(5'd5, 1'b0, SEW32, 2'b11);
    resp(1'b0, 32'hCAFEF00D, 2'd0);
    bus.flush    = 1'b1;
    bus.start    = 1'b1;
    bus.vmemdren = 1'b1;
    tick();
    bus.flush    = 1'b0;
    bus.start    = 1'b0;
    bus.vmemdren = 1'b0;
    @(negedge CLK);
    checks++; if (bus.busy !== 1'b0)     begin failures++; $display("FAIL flush_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.wb_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", bus.wb_valid); end
    resp(1'b1, 32'hBADBAD00, 2'd0);
    tick();
    @(negedge CLK);
    checks++; if (bus.busy !== 1'b0)   begin failures++; $display("FAIL late_resp_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.err !== ERRCHK)  begin failures++; $display("FAIL late_resp_err got=%b exp=%b", bus.err, ERRCHK); end
    sb_q.push_back('{data: 64'h66666666_55555555, mask: 2'b11, uop: 5'd6, last: 1'b1});
    issue(5'd6, 1'b1, SEW32, 2'b11);
    resp(1'b1, 32'h66666666, 2'd0);
    resp(1'b0, 32'h55555555, 2'd0);
    @(negedge CLK);
    checks++; if (bus.wb_valid !== 1'b1) begin failures++; $display("FAIL post_flush_valid got=%b exp=1", bus.wb_valid); end
    tick();
  endtask

  task automatic test_async_reset();
    tick();
    bus.wb_ready = 1'b0;
    issue(5'd9, 1'b1, SEW32, 2'b11);
    resp(1'b0, 32'h77777777, 2'd0);
    #2;
    RST = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0)       begin failures++; $display("FAIL arst_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.wb_data !== 64'd0)   begin failures++; $display("FAIL arst_data got=%h exp=0", bus.wb_data); end
    checks++; if (bus.wb_mask !== 2'b00)   begin failures++; $display("FAIL arst_mask got=%b exp=00", bus.wb_mask); end
    checks++; if (bus.wb_uop_num !== 5'd0) begin failures++; $display("FAIL arst_uop got=%0d exp=0", bus.wb_uop_num); end
    checks++; if (bus.err !== 1'b0)        begin failures++; $display("FAIL arst_err got=%b exp=0", bus.err); end
    tick();
    RST = 1'b0;
    tick();
    @(negedge CLK);
    checks++; if (bus.busy !== 1'b0)     begin failures++; $display("FAIL arst_after_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.wb_valid !== 1'b0) begin failures++; $display("FAIL arst_after_valid got=%b exp=0", bus.wb_valid); end
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    RST            = 1'b1;
    bus.start      = 1'b0;
    bus.vmemdren   = 1'b0;
    bus.vuop_num   = 5'd0;
    bus.vuop_last  = 1'b0;
    bus.veew       = SEW32;
    bus.vlane_mask = 2'b00;
    bus.lsc_rvalid = 1'b0;
    bus.lsc_rlane  = 1'b0;
    bus.lsc_rdata  = 32'd0;
    bus.lsc_boff   = 2'd0;
    bus.flush      = 1'b0;
    bus.wb_ready   = 1'b0;

    test_reset();
    test_sew32();
    test_sew8_masked();
    test_sew16();
    test_all_masked();
    test_back_to_back();
    test_err_dup();
    test_flush();
    test_async_reset();

    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover got=%0d beats exp=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
